// File: rtl/jtag_pkg.sv
// Shared constants and FSM state type for the JTAG-DP command sequencer.
package jtag_pkg;

  // PHY packet command codes.
  localparam logic [2:0] CMD_TAP_RESET = 3'b000;
  localparam logic [2:0] CMD_RD_DR     = 3'b001;
  localparam logic [2:0] CMD_WR_DR     = 3'b010;
  localparam logic [2:0] CMD_RD_IR     = 3'b011;
  localparam logic [2:0] CMD_WR_IR     = 3'b100;
  localparam logic [2:0] CMD_RD_DR_EXT = 3'b101;
  localparam logic [2:0] CMD_WR_DR_EXT = 3'b110;
  localparam logic [2:0] CMD_RD_IR_EXT = 3'b111;

  // JTAG-DP instruction register values.
  localparam logic [3:0] IR_ABORT  = 4'h8;
  localparam logic [3:0] IR_DPACC  = 4'hA;
  localparam logic [3:0] IR_APACC  = 4'hB;
  localparam logic [3:0] IR_IDCODE = 4'hE;

  // Scan acknowledge codes.
  localparam logic [2:0] ACK_OK   = 3'b010;
  localparam logic [2:0] ACK_WAIT = 3'b001;

  // DPACC/APACC scan length: {data[31:0], A[3:2], RnW}.
  localparam int unsigned DR_LEN = 35;

  typedef enum logic [3:0] {
    StReset,
    StIdle,
    StIrChk,
    StIrIssue,
    StDrIssue,
    StDrWait,
    StEval,
    StRdIr,
    StRbIssue,
    StResp
  } state_t;

endpackage

// File: rtl/jtag_dap_pack.sv
// DR scan packing and MSB-aligned capture extraction for DPACC/APACC scans.
module jtag_dap_pack
  import jtag_pkg::*;
#(
  parameter int unsigned BUF_SZ = 64
) (
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_addr,
  input  logic              i_rnw,
  input  logic [BUF_SZ-1:0] i_din,
  output logic [BUF_SZ-1:0] o_dr,
  output logic [2:0]        o_ack,
  output logic [31:0]       o_rdata
);

  logic [DR_LEN-1:0] w_cap;
  logic              w_unused_din;

  // Scan goes out LSB first, so RnW sits in bit 0.
  assign o_dr = BUF_SZ'({i_wdata, i_addr, i_rnw});

  // The PHY shifts captured bits in from the top, leaving them MSB-aligned.
  assign w_cap        = i_din[BUF_SZ-1 -: DR_LEN];
  assign o_ack        = w_cap[2:0];
  assign o_rdata      = w_cap[DR_LEN-1:3];
  assign w_unused_din = ^i_din;

endmodule

// File: rtl/jtag_dap_seq.sv
// Converts DPACC/APACC requests into jtag_phy packets and parses the scan results.
module jtag_dap_seq
  import jtag_pkg::*;
#(
  parameter int unsigned BUF_SZ       = 64,
  parameter int unsigned MAX_CLEN     = 4096,
  parameter int unsigned IR_LEN       = 4,
  parameter int unsigned WAIT_RETRIES = 8,
  localparam int unsigned LW          = $clog2(MAX_CLEN),
  localparam int unsigned FIFO_IN_SZ  = BUF_SZ + 3 + LW,
  localparam int unsigned FIFO_OUT_SZ = BUF_SZ + $clog2(BUF_SZ)
) (
  input  logic                   PHY_CLK,
  input  logic                   RESETn,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic                   REQ_APNDP,
  input  logic                   REQ_RNW,
  input  logic [1:0]             REQ_ADDR,
  input  logic [31:0]            REQ_WDATA,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic [31:0]            RSP_DATA,
  output logic [2:0]             RSP_ACK,
  output logic [FIFO_IN_SZ-1:0]  PHY_WRDATA,
  output logic                   PHY_WREN,
  input  logic                   PHY_WRFULL,
  input  logic [FIFO_OUT_SZ-1:0] PHY_RDDATA,
  output logic                   PHY_RDEN,
  input  logic                   PHY_RDEMPTY
);

  localparam int unsigned RW = $clog2(WAIT_RETRIES + 1);

  state_t          r_state, w_state_next;
  logic            r_apndp, r_rnw, r_rb, r_ir_valid;
  logic [1:0]      r_addr;
  logic [31:0]     r_wdata, r_rdata, r_rsp_data;
  logic [3:0]      r_ir;
  logic [2:0]      r_ack, r_rsp_ack;
  logic [RW-1:0]   r_retry;

  logic [3:0]            w_ir_need, w_ir_data;
  logic                  w_ir_hit, w_dp_hit, w_wait_retry;
  logic [BUF_SZ-1:0]     w_dr;
  logic [2:0]            w_cap_ack;
  logic [31:0]           w_cap_rdata;
  logic [FIFO_IN_SZ-1:0] w_ir_pkt, w_dr_pkt;
  logic                  w_unused_ilen;

  assign w_ir_need    = r_apndp ? IR_APACC : IR_DPACC;
  assign w_ir_hit     = r_ir_valid && (r_ir == w_ir_need);
  assign w_dp_hit     = r_ir_valid && (r_ir == IR_DPACC);
  assign w_wait_retry = (r_ack == ACK_WAIT) && (r_retry < RW'(WAIT_RETRIES));
  // RDBUFF collection always goes through DPACC, regardless of the request.
  assign w_ir_data    = (r_state == StRdIr) ? IR_DPACC : w_ir_need;
  assign w_ir_pkt     = {BUF_SZ'(w_ir_data), LW'(IR_LEN), CMD_WR_IR};
  assign w_dr_pkt     = {w_dr, LW'(DR_LEN), CMD_RD_DR};

  assign RSP_DATA      = r_rsp_data;
  assign RSP_ACK       = r_rsp_ack;
  assign w_unused_ilen = ^PHY_RDDATA[FIFO_OUT_SZ-BUF_SZ-1:0];

  jtag_dap_pack #(
    .BUF_SZ (BUF_SZ)
  ) u_pack (
    .i_wdata (r_wdata),
    .i_addr  (r_addr),
    .i_rnw   (r_rnw),
    .i_din   (PHY_RDDATA[FIFO_OUT_SZ-1 -: BUF_SZ]),
    .o_dr    (w_dr),
    .o_ack   (w_cap_ack),
    .o_rdata (w_cap_rdata)
  );

  // State register; reset re-enters the TAP-reset packet state.
  always_ff @(posedge PHY_CLK) begin
    if (!RESETn) r_state <= StReset;
    else         r_state <= w_state_next;
  end

  // Next-state logic; FIFO full/empty stalls the current state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StReset:   if (!PHY_WRFULL) w_state_next = StIdle;
      StIdle:    if (REQ_VALID) w_state_next = StIrChk;
      StIrChk:   w_state_next = w_ir_hit ? StDrIssue : StIrIssue;
      StIrIssue: if (!PHY_WRFULL) w_state_next = StDrIssue;
      StDrIssue: if (!PHY_WRFULL) w_state_next = StDrWait;
      StDrWait:  if (!PHY_RDEMPTY) w_state_next = StEval;
      StEval: begin
        if (w_wait_retry)                          w_state_next = StDrIssue;
        else if (r_ack == ACK_OK && !r_rb && r_rnw) w_state_next = StRdIr;
        else                                        w_state_next = StResp;
      end
      StRdIr:    if (w_dp_hit || !PHY_WRFULL) w_state_next = StRbIssue;
      StRbIssue: if (!PHY_WRFULL) w_state_next = StDrWait;
      StResp:    if (RSP_READY) w_state_next = StIdle;
      default:   w_state_next = StReset;
    endcase
  end

  // Handshake strobes and packet data; PHY_WRDATA is zero whenever no packet is written.
  always_comb begin
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    PHY_WREN   = 1'b0;
    PHY_RDEN   = 1'b0;
    PHY_WRDATA = '0;
    unique case (r_state)
      StReset:   PHY_WREN = RESETn && !PHY_WRFULL;
      StIdle:    REQ_READY = 1'b1;
      StIrIssue: begin
        PHY_WREN = !PHY_WRFULL;
        if (!PHY_WRFULL) PHY_WRDATA = w_ir_pkt;
      end
      StDrIssue, StRbIssue: begin
        PHY_WREN = !PHY_WRFULL;
        if (!PHY_WRFULL) PHY_WRDATA = w_dr_pkt;
      end
      StDrWait:  PHY_RDEN = !PHY_RDEMPTY;
      StRdIr: begin
        PHY_WREN = !w_dp_hit && !PHY_WRFULL;
        if (!w_dp_hit && !PHY_WRFULL) PHY_WRDATA = w_ir_pkt;
      end
      StResp:    RSP_VALID = 1'b1;
      default:   ;
    endcase
  end

  // Request latch, IR cache, capture, retry counter and response registers.
  always_ff @(posedge PHY_CLK) begin
    if (!RESETn) begin
      r_apndp    <= 1'b0;
      r_rnw      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rb       <= 1'b0;
      r_ir_valid <= 1'b0;
      r_ir       <= '0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_retry    <= '0;
      r_rsp_data <= '0;
      r_rsp_ack  <= '0;
    end else begin
      unique case (r_state)
        StIdle: if (REQ_VALID) begin
          r_apndp <= REQ_APNDP;
          r_rnw   <= REQ_RNW;
          r_addr  <= REQ_ADDR;
          r_wdata <= REQ_WDATA;
          r_rb    <= 1'b0;
        end
        StIrIssue: if (!PHY_WRFULL) begin
          r_ir_valid <= 1'b1;
          r_ir       <= w_ir_need;
        end
        StDrWait: if (!PHY_RDEMPTY) begin
          r_ack   <= w_cap_ack;
          r_rdata <= w_cap_rdata;
        end
        StEval: begin
          if (w_wait_retry) begin
            r_retry <= r_retry + 1'b1;
          end else if (r_ack == ACK_OK && r_rb) begin
            r_rsp_ack  <= r_ack;
            r_rsp_data <= r_rdata;
          end else if (!(r_ack == ACK_OK && r_rnw)) begin
            r_rsp_ack  <= r_ack;
            r_rsp_data <= '0;
          end
        end
        StRdIr: begin
          if (!w_dp_hit && !PHY_WRFULL) begin
            r_ir_valid <= 1'b1;
            r_ir       <= IR_DPACC;
          end
          // Retarget the scan registers at RDBUFF so WAIT retries replay the same scan.
          r_wdata <= '0;
          r_addr  <= 2'b11;
          r_rnw   <= 1'b1;
          r_rb    <= 1'b1;
        end
        StResp: if (RSP_READY) begin
          r_retry <= '0;
          r_rb    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
